alu_sched: RTL and testbench

ALU_SCHED -- requirements
Module: alu_sched

---
 rtl/alu_sched_if.sv | 31 +++
 rtl/alu_sched.sv | 95 +++++++++
 tb/tb_alu_sched.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sched_if.sv
// Handshake and shared-ALU bus between two requesters, the scheduler and the ALU.
// slave = scheduler side, master = requesters plus ALU side.
interface alu_sched_if;
  logic       req0, req1;
  logic [1:0] o0, o1;
  logic [2:0] s0, s1;
  logic [7:0] a0, b0, a1, b1;
  logic       cin0, cin1;
  logic       gnt0, gnt1, done0, done1;
  logic [7:0] res;
  logic       cout;
  logic       busy;
  logic [1:0] alu_O;
  logic [2:0] alu_S;
  logic [7:0] alu_A, alu_B;
  logic       alu_C1, alu_G;
  logic [7:0] alu_F;
  logic       alu_C2;

  modport slave (
    input  req0, req1, o0, o1, s0, s1, a0, b0, a1, b1, cin0, cin1, alu_F, alu_C2,
    output gnt0, gnt1, done0, done1, res, cout, busy,
           alu_O, alu_S, alu_A, alu_B, alu_C1, alu_G
  );

  modport master (
    output req0, req1, o0, o1, s0, s1, a0, b0, a1, b1, cin0, cin1, alu_F, alu_C2,
    input  gnt0, gnt1, done0, done1, res, cout, busy,
           alu_O, alu_S, alu_A, alu_B, alu_C1, alu_G
  );
endinterface

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one ALU between two requesters.
// IDLE -> EXEC (1 or 2 cycles by op) -> DONE -> IDLE; all ALU drives registered.
module alu_sched (
  input  logic      clk,
  input  logic      rst,
  alu_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  typedef struct packed {
    logic [1:0] o;
    logic [2:0] s;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
  } op_t;

  state_t state, state_n;
  op_t    op0, op1, win_op;
  logic   last;     // last-served requester; also owner of the op in flight
  logic   pick1;
  logic   take;
  logic   finish;
  logic   cnt;      // EXEC cycles remaining after the current one

  assign op0 = {bus.o0, bus.s0, bus.a0, bus.b0, bus.cin0};
  assign op1 = {bus.o1, bus.s1, bus.a1, bus.b1, bus.cin1};

  // Requester 1 wins alone, or on a tie when requester 0 was served last.
  assign pick1  = bus.req1 & (~bus.req0 | ~last);
  assign win_op = pick1 ? op1 : op0;

  assign bus.busy = (state != IDLE);

  always_comb begin
    state_n = state;
    take    = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: if (bus.req0 | bus.req1) begin
        take    = 1'b1;
        state_n = EXEC;
      end
      EXEC: if (cnt == 1'b0) begin
        finish  = 1'b1;
        state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.gnt0   <= 1'b0;
      bus.gnt1   <= 1'b0;
      bus.done0  <= 1'b0;
      bus.done1  <= 1'b0;
      bus.res    <= 8'h00;
      bus.cout   <= 1'b0;
      bus.alu_O  <= 2'b00;
      bus.alu_S  <= 3'b000;
      bus.alu_A  <= 8'h00;
      bus.alu_B  <= 8'h00;
      bus.alu_C1 <= 1'b0;
      bus.alu_G  <= 1'b1;
      last       <= 1'b1;
      cnt        <= 1'b0;
    end else begin
      bus.gnt0  <= take & ~pick1;
      bus.gnt1  <= take & pick1;
      bus.done0 <= finish & ~last;
      bus.done1 <= finish & last;
      if (take) begin
        {bus.alu_O, bus.alu_S, bus.alu_A, bus.alu_B, bus.alu_C1} <= win_op;
        bus.alu_G <= 1'b0;
        last      <= pick1;
        // shift and count need a second EXEC cycle
        cnt       <= (win_op.o == 2'b01) || (win_op.o == 2'b10);
      end else if (state == EXEC && !finish) begin
        cnt <= cnt - 1'b1;
      end
      if (finish) begin
        bus.res   <= bus.alu_F;
        bus.cout  <= bus.alu_C2;
        bus.alu_G <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_sched.sv
// Randomized scoreboard bench for alu_sched with a behavioural ALU and scheduler model.
module tb_alu_sched;
  logic clk = 1'b0;
  logic rst;
  alu_sched_if bus();

  alu_sched dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // {carry, result} of the stand-in ALU
  function automatic logic [8:0] alu_fn(input logic [1:0] o, input logic [2:0] s,
                                        input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [7:0] f;
    logic [8:0] r;
    f = 8'h00;
    r = 9'h000;
    case (o)
      2'd0: r = {1'b0, a} + {1'b0, b} + {8'h00, c};
      2'd1: r = {a, c};
      2'd2: r = c ? {1'b0, b} : ({1'b0, a} + 9'd1);
      default: begin
        case (s)
          3'd0: f = a & b;
          3'd1: f = a | b;
          3'd2: f = a ^ b;
          3'd3: f = ~(a & b);
          3'd4: f = ~(a | b);
          3'd5: f = ~(a ^ b);
          3'd6: f = a;
          default: f = ~a;
        endcase
        r = {1'b0, f};
      end
    endcase
    return r;
  endfunction

  assign {bus.alu_C2, bus.alu_F} = alu_fn(bus.alu_O, bus.alu_S, bus.alu_A, bus.alu_B, bus.alu_C1);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         id;
    logic [8:0] rc;
  } txn_t;
  txn_t sbq[$];

  logic        mvalid = 1'b0;
  int          mrem;          // edges still to pass before a new grant can happen
  int          mowner;
  logic        mlast;
  logic [1:0]  exp_gnt, exp_done;
  logic        exp_busy, exp_g;
  logic [21:0] exp_alu;
  logic [8:0]  exp_rc, mcur;

  initial begin
    logic [21:0] op;
    int w;
    forever begin
      @(posedge clk);
      exp_gnt  = 2'b00;
      exp_done = 2'b00;
      if (rst) begin
        mvalid  = 1'b1;
        mrem    = 0;
        mlast   = 1'b1;
        exp_alu = '0;
        exp_rc  = '0;
        sbq.delete();
      end else if (mrem > 0) begin
        mrem--;
        if (mrem == 1) begin
          exp_done[mowner] = 1'b1;
          exp_rc = mcur;
        end
      end else if (bus.req0 || bus.req1) begin
        if (bus.req0 && bus.req1) w = mlast ? 0 : 1;
        else                      w = bus.req1 ? 1 : 0;
        op = (w == 1) ? {bus.o1, bus.s1, bus.a1, bus.b1, bus.cin1}
                      : {bus.o0, bus.s0, bus.a0, bus.b0, bus.cin0};
        mowner     = w;
        mlast      = (w == 1);
        exp_gnt[w] = 1'b1;
        exp_alu    = op;
        mcur       = alu_fn(op[21:20], op[19:17], op[16:9], op[8:1], op[0]);
        // EXEC length plus the DONE cycle
        mrem       = (op[21:20] == 2'd1 || op[21:20] == 2'd2) ? 3 : 2;
        sbq.push_back('{w, mcur});
      end
      exp_busy = (mrem > 0);
      exp_g    = !(mrem > 1);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      if (mvalid && !rst) begin
        chk("gnt",      {30'd0, bus.gnt1, bus.gnt0}, {30'd0, exp_gnt});
        chk("done",     {30'd0, bus.done1, bus.done0}, {30'd0, exp_done});
        chk("gnt_overlap", {31'd0, bus.gnt0 & bus.gnt1}, 32'd0);
        chk("busy",     {31'd0, bus.busy}, {31'd0, exp_busy});
        chk("alu_G",    {31'd0, bus.alu_G}, {31'd0, exp_g});
        chk("alu_regs", {10'd0, bus.alu_O, bus.alu_S, bus.alu_A, bus.alu_B, bus.alu_C1}, {10'd0, exp_alu});
        chk("res_cout", {23'd0, bus.cout, bus.res}, {23'd0, exp_rc});
        if (bus.done0 || bus.done1) begin
          if (sbq.size() == 0) begin
            chk("sb_unexpected_done", 32'd1, 32'd0);
          end else begin
            t = sbq.pop_front();
            chk("sb_id",     {31'd0, bus.done1}, t.id);
            chk("sb_result", {23'd0, bus.cout, bus.res}, {23'd0, t.rc});
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_op(input int id, input logic [1:0] o, input logic [2:0] s,
                       input logic [7:0] a, input logic [7:0] b, input logic c, input int hold);
    bit got = 1'b0;
    if (id == 0) begin
      bus.o0 = o; bus.s0 = s; bus.a0 = a; bus.b0 = b; bus.cin0 = c; bus.req0 = 1'b1;
    end else begin
      bus.o1 = o; bus.s1 = s; bus.a1 = a; bus.b1 = b; bus.cin1 = c; bus.req1 = 1'b1;
    end
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if ((id == 0) ? bus.gnt0 : bus.gnt1) got = 1'b1;
    end
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL gnt_timeout: requester %0d got no grant within 60 cycles", id);
    end
    repeat (hold) @(negedge clk);
    if (id == 0) bus.req0 = 1'b0;
    else         bus.req1 = 1'b0;
  endtask

  task automatic rand_ops(input int id, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      do_op(id, 2'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.o0 = '0; bus.s0 = '0; bus.a0 = '0; bus.b0 = '0; bus.cin0 = 1'b0;
    bus.o1 = '0; bus.s1 = '0; bus.a1 = '0; bus.b1 = '0; bus.cin1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_res_cout", {23'd0, bus.cout, bus.res}, 32'd0);
    chk("rst_alu_regs", {10'd0, bus.alu_O, bus.alu_S, bus.alu_A, bus.alu_B, bus.alu_C1}, 32'd0);
    chk("rst_alu_G",    {31'd0, bus.alu_G}, 32'd1);
    chk("rst_busy",     {31'd0, bus.busy}, 32'd0);
    chk("rst_pulses",   {28'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1}, 32'd0);
    rst = 1'b0;

    // single add from requester 0, then an add with carry out from requester 1
    do_op(0, 2'b00, 3'd0, 8'h0F, 8'h01, 1'b0, 0);
    repeat (4) @(negedge clk);
    chk("add0_res", {23'd0, bus.cout, bus.res}, 32'h010);
    do_op(1, 2'b00, 3'd0, 8'hFF, 8'h01, 1'b0, 0);
    repeat (4) @(negedge clk);
    chk("add1_res", {23'd0, bus.cout, bus.res}, 32'h100);

    // both held: alternating grants
    fork
      do_op(0, 2'b11, 3'd2, 8'hA5, 8'h3C, 1'b0, 12);
      do_op(1, 2'b01, 3'd0, 8'h81, 8'h00, 1'b1, 12);
    join
    repeat (6) @(negedge clk);

    // a request arriving during EXEC waits for IDLE
    do_op(0, 2'b01, 3'd0, 8'h40, 8'h00, 1'b0, 0);
    do_op(1, 2'b11, 3'd5, 8'h12, 8'h34, 1'b0, 0);
    repeat (6) @(negedge clk);

    // reset in the first EXEC cycle of a count op
    do_op(0, 2'b10, 3'd0, 8'h07, 8'h00, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_res_cout", {23'd0, bus.cout, bus.res}, 32'd0);
    chk("abort_busy",     {31'd0, bus.busy}, 32'd0);
    chk("abort_pulses",   {28'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1}, 32'd0);
    chk("abort_alu_G",    {31'd0, bus.alu_G}, 32'd1);
    rst = 1'b0;
    fork
      do_op(0, 2'b10, 3'd0, 8'hFF, 8'h00, 1'b0, 0);
      do_op(1, 2'b11, 3'd7, 8'h0F, 8'h00, 1'b0, 0);
    join
    repeat (6) @(negedge clk);

    fork
      rand_ops(0, 40);
      rand_ops(1, 40);
    join
    repeat (8) @(negedge clk);
    chk("sb_drained", sbq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
